chip8_sprite_engine: RTL and testbench

Multi-cycle DXYN / 00E0 engine for the CHIP-8 core. Reads sprite bytes from program memory and XOR-draws them row by row into an external row-organised framebuffer RAM, reporting pixel collision (VF). Generalises the single-row draw path to parametrised display size, selectable wrap/clip edge policy, full N-row sprites, and a hardware screen clear. It sits between the instruction decoder and the framebuffer RAM.

---
 rtl/chip8_sprite_engine.sv | 185 ++++++++++++++++++
 tb/tb_chip8_sprite_engine.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_sprite_engine.sv
// ---------------------------------------------------------------------------
// chip8_sprite_engine
//
// Multi-cycle DXYN / 00E0 engine. Fetches sprite bytes from program memory
// one row at a time, XOR-draws each into a row-organised framebuffer RAM
// (read row, write row back) and accumulates the VF collision flag. A clear
// request writes all-zero rows over the whole display instead.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, clear        draw / clear-screen request (clear wins), IDLE only
//   x, y, n, i_addr     sprite origin, height (rows) and base address
//   mem_addr            sprite byte address (data returns next cycle)
//   mem_rd_data         sprite byte
//   fb_rd_addr          framebuffer row read address (data returns next cycle)
//   fb_rd_data          framebuffer row, bit DISP_W-1 is column 0
//   fb_wr_en/addr/data  framebuffer row write port
//   busy                high whenever the engine is not idle
//   done                one-cycle completion pulse
//   collision           VF result, held until the next accepted request
// ---------------------------------------------------------------------------
module chip8_sprite_engine #(
    parameter int DISP_W = 64,
    parameter int DISP_H = 32,
    parameter int ADDR_W = 12,
    parameter int WRAP   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      clear,
    input  logic [$clog2(DISP_W)-1:0] x,
    input  logic [$clog2(DISP_H)-1:0] y,
    input  logic [3:0]                n,
    input  logic [ADDR_W-1:0]         i_addr,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [7:0]                mem_rd_data,
    output logic [$clog2(DISP_H)-1:0] fb_rd_addr,
    input  logic [DISP_W-1:0]         fb_rd_data,
    output logic                      fb_wr_en,
    output logic [$clog2(DISP_H)-1:0] fb_wr_addr,
    output logic [DISP_W-1:0]         fb_wr_data,
    output logic                      busy,
    output logic                      done,
    output logic                      collision
);

    localparam int XW = $clog2(DISP_W);
    localparam int YW = $clog2(DISP_H);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WRITE,
        CLEAR,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [XW-1:0]       xOrg_q, xOrg_d;
    logic [YW-1:0]       yOrg_q, yOrg_d;
    logic [3:0]          nRows_q, nRows_d;
    logic [ADDR_W-1:0]   baseAddr_q, baseAddr_d;
    logic [YW-1:0]       row_q, row_d;
    logic                coll_q, coll_d;

    logic [2*DISP_W-1:0] spread;
    logic [DISP_W-1:0]   mask;
    logic [YW-1:0]       drawRow;
    logic                lastRow;
    logic                bottomClip;

    // The sprite byte is placed at the far left of a double-width vector and
    // shifted right by x. The upper half then holds the on-screen columns and
    // the lower half holds columns that ran past the right edge, which are
    // either folded back onto column 0.. (wrap) or discarded (clip).
    always_comb begin
        spread = {mem_rd_data, {(2*DISP_W-8){1'b0}}} >> xOrg_q;
        mask   = spread[2*DISP_W-1:DISP_W];
        if (WRAP != 0) begin
            mask = mask | spread[DISP_W-1:0];
        end
    end

    // Row address wraps modulo DISP_H for free through the narrow adder.
    // The clip test uses one extra bit so it sees the row that would fall
    // off the bottom before it wraps.
    assign drawRow    = yOrg_q + row_q;
    assign lastRow    = (row_q + YW'(1)) == YW'(nRows_q);
    assign bottomClip = (WRAP == 0) &&
                        (({1'b0, yOrg_q} + {1'b0, row_q} + (YW+1)'(1)) >= (YW+1)'(DISP_H));

    always_comb begin
        state_d    = state_q;
        xOrg_d     = xOrg_q;
        yOrg_d     = yOrg_q;
        nRows_d    = nRows_q;
        baseAddr_d = baseAddr_q;
        row_d      = row_q;
        coll_d     = coll_q;
        mem_addr   = '0;
        fb_rd_addr = '0;
        fb_wr_en   = 1'b0;
        fb_wr_addr = '0;
        fb_wr_data = '0;

        case (state_q)
            IDLE: begin
                if (clear || start) begin
                    xOrg_d     = x;
                    yOrg_d     = y;
                    nRows_d    = n;
                    baseAddr_d = i_addr;
                    row_d      = '0;
                    coll_d     = 1'b0;
                    if (clear) begin
                        state_d = CLEAR;
                    end else if (n == 4'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                mem_addr   = baseAddr_q + ADDR_W'(row_q);
                fb_rd_addr = drawRow;
                state_d    = WRITE;
            end
            WRITE: begin
                fb_rd_addr = drawRow;
                fb_wr_en   = 1'b1;
                fb_wr_addr = drawRow;
                fb_wr_data = fb_rd_data ^ mask;
                coll_d     = coll_q | (|(fb_rd_data & mask));
                if (lastRow || bottomClip) begin
                    state_d = DONE;
                end else begin
                    row_d   = row_q + YW'(1);
                    state_d = FETCH;
                end
            end
            CLEAR: begin
                fb_wr_en   = 1'b1;
                fb_wr_addr = row_q;
                if (row_q == YW'(DISP_H - 1)) begin
                    state_d = DONE;
                end else begin
                    row_d = row_q + YW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            xOrg_q     <= '0;
            yOrg_q     <= '0;
            nRows_q    <= '0;
            baseAddr_q <= '0;
            row_q      <= '0;
            coll_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            xOrg_q     <= xOrg_d;
            yOrg_q     <= yOrg_d;
            nRows_q    <= nRows_d;
            baseAddr_q <= baseAddr_d;
            row_q      <= row_d;
            coll_q     <= coll_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign collision = coll_q;

endmodule

// File: tb/tb_chip8_sprite_engine.sv
// ---------------------------------------------------------------------------
// tb_chip8_sprite_engine
//
// Three engines share one clock: A (64x32, wrap), B (64x32, clip) and
// C (128x64, wrap). Each has its own behavioural program memory port and
// framebuffer RAM with one-cycle read latency. Stimulus pushes hand-computed
// expected row writes and completions into queues; a monitor pops and
// compares them whenever an engine writes a row or pulses done. Only one
// engine is active at a time, so a single pair of queues tagged by engine
// id is enough.
// ---------------------------------------------------------------------------
module tb_chip8_sprite_engine;

    typedef struct {
        int           id;
        int           addr;
        logic [127:0] data;
    } wrExp_t;

    typedef struct {
        int   id;
        int   cyc;
        logic coll;
    } doneExp_t;

    logic clk;
    logic fbInit;
    int   cycleCnt = 0;
    int   baseCycle = 0;
    int   doneCount = 0;
    int   checks = 0;
    int   failures = 0;

    wrExp_t   expWrQ[$];
    doneExp_t expDoneQ[$];

    logic [7:0] progMem [4096];

    // Engine A: 64x32, wrap
    logic        rstA, startA, clearA;
    logic [5:0]  xA;
    logic [4:0]  yA;
    logic [3:0]  nA;
    logic [11:0] iA, memAddrA;
    logic [7:0]  memRdA;
    logic [4:0]  fbRdAddrA, fbWrAddrA;
    logic [63:0] fbRdDataA, fbWrDataA;
    logic        fbWrEnA, busyA, doneA, collA;
    logic [63:0] fbA [32];

    // Engine B: 64x32, clip
    logic        rstB, startB, clearB;
    logic [5:0]  xB;
    logic [4:0]  yB;
    logic [3:0]  nB;
    logic [11:0] iB, memAddrB;
    logic [7:0]  memRdB;
    logic [4:0]  fbRdAddrB, fbWrAddrB;
    logic [63:0] fbRdDataB, fbWrDataB;
    logic        fbWrEnB, busyB, doneB, collB;
    logic [63:0] fbB [32];

    // Engine C: 128x64, wrap
    logic         rstC, startC, clearC;
    logic [6:0]   xC;
    logic [5:0]   yC;
    logic [3:0]   nC;
    logic [11:0]  iC, memAddrC;
    logic [7:0]   memRdC;
    logic [5:0]   fbRdAddrC, fbWrAddrC;
    logic [127:0] fbRdDataC, fbWrDataC;
    logic         fbWrEnC, busyC, doneC, collC;
    logic [127:0] fbC [64];

    chip8_sprite_engine u_a (
        .clk(clk), .rst(rstA), .start(startA), .clear(clearA),
        .x(xA), .y(yA), .n(nA), .i_addr(iA),
        .mem_addr(memAddrA), .mem_rd_data(memRdA),
        .fb_rd_addr(fbRdAddrA), .fb_rd_data(fbRdDataA),
        .fb_wr_en(fbWrEnA), .fb_wr_addr(fbWrAddrA), .fb_wr_data(fbWrDataA),
        .busy(busyA), .done(doneA), .collision(collA)
    );

    chip8_sprite_engine #(.WRAP(0)) u_b (
        .clk(clk), .rst(rstB), .start(startB), .clear(clearB),
        .x(xB), .y(yB), .n(nB), .i_addr(iB),
        .mem_addr(memAddrB), .mem_rd_data(memRdB),
        .fb_rd_addr(fbRdAddrB), .fb_rd_data(fbRdDataB),
        .fb_wr_en(fbWrEnB), .fb_wr_addr(fbWrAddrB), .fb_wr_data(fbWrDataB),
        .busy(busyB), .done(doneB), .collision(collB)
    );

    chip8_sprite_engine #(.DISP_W(128), .DISP_H(64)) u_c (
        .clk(clk), .rst(rstC), .start(startC), .clear(clearC),
        .x(xC), .y(yC), .n(nC), .i_addr(iC),
        .mem_addr(memAddrC), .mem_rd_data(memRdC),
        .fb_rd_addr(fbRdAddrC), .fb_rd_data(fbRdDataC),
        .fb_wr_en(fbWrEnC), .fb_wr_addr(fbWrAddrC), .fb_wr_data(fbWrDataC),
        .busy(busyC), .done(doneC), .collision(collC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Memory models: registered reads, framebuffer writes on the clock edge.
    always @(posedge clk) begin
        if (fbInit) begin
            for (int r = 0; r < 32; r++) begin
                fbA[r] <= '0;
                fbB[r] <= '0;
            end
            for (int r = 0; r < 64; r++) begin
                fbC[r] <= '0;
            end
        end else begin
            if (fbWrEnA) fbA[fbWrAddrA] <= fbWrDataA;
            if (fbWrEnB) fbB[fbWrAddrB] <= fbWrDataB;
            if (fbWrEnC) fbC[fbWrAddrC] <= fbWrDataC;
        end
        fbRdDataA <= fbA[fbRdAddrA];
        fbRdDataB <= fbB[fbRdAddrB];
        fbRdDataC <= fbC[fbRdAddrC];
        memRdA    <= progMem[memAddrA];
        memRdB    <= progMem[memAddrB];
        memRdC    <= progMem[memAddrC];
    end

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic pushWr(input int id, input int addr, input logic [127:0] data);
        wrExp_t e;
        e.id   = id;
        e.addr = addr;
        e.data = data;
        expWrQ.push_back(e);
    endtask

    task automatic pushDone(input int id, input int cyc, input logic coll);
        doneExp_t e;
        e.id   = id;
        e.cyc  = cyc;
        e.coll = coll;
        expDoneQ.push_back(e);
    endtask

    task automatic observeWrite(input int id, input int addr, input logic [127:0] data);
        wrExp_t e;
        if (expWrQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpectedWrite engine=%0d row=%0d data=%0h", id, addr, data);
        end else begin
            e = expWrQ.pop_front();
            checkOutput("wrEngine", 128'(id), 128'(e.id));
            checkOutput("wrRow", 128'(addr), 128'(e.addr));
            checkOutput("wrData", data, e.data);
        end
    endtask

    task automatic observeDone(input int id, input logic coll);
        doneExp_t e;
        doneCount++;
        if (expDoneQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpectedDone engine=%0d cycle=%0d", id, cycleCnt - baseCycle);
        end else begin
            e = expDoneQ.pop_front();
            checkOutput("doneEngine", 128'(id), 128'(e.id));
            checkOutput("doneCycle", 128'(cycleCnt - baseCycle), 128'(e.cyc));
            checkOutput("collision", 128'(coll), 128'(e.coll));
            checkOutput("pendingWritesAtDone", 128'(expWrQ.size()), 128'(0));
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (fbWrEnA) observeWrite(0, int'(fbWrAddrA), {64'h0, fbWrDataA});
        if (fbWrEnB) observeWrite(1, int'(fbWrAddrB), {64'h0, fbWrDataB});
        if (fbWrEnC) observeWrite(2, int'(fbWrAddrC), fbWrDataC);
        if (doneA) observeDone(0, collA);
        if (doneB) observeDone(1, collB);
        if (doneC) observeDone(2, collC);
    end

    function automatic logic busyOf(input int id);
        case (id)
            0:       return busyA;
            1:       return busyB;
            default: return busyC;
        endcase
    endfunction

    task automatic driveReq(input int id, input logic clr, input logic st,
                            input int xv, input int yv, input int nv, input int ia);
        case (id)
            0: begin
                clearA = clr; startA = st; xA = 6'(xv); yA = 5'(yv); nA = 4'(nv); iA = 12'(ia);
            end
            1: begin
                clearB = clr; startB = st; xB = 6'(xv); yB = 5'(yv); nB = 4'(nv); iB = 12'(ia);
            end
            default: begin
                clearC = clr; startC = st; xC = 7'(xv); yC = 6'(yv); nC = 4'(nv); iC = 12'(ia);
            end
        endcase
    endtask

    task automatic releaseReq();
        startA = 1'b0; clearA = 1'b0;
        startB = 1'b0; clearB = 1'b0;
        startC = 1'b0; clearC = 1'b0;
    endtask

    // Issues one request (accepted at relative cycle 0) and waits, bounded,
    // for the monitor to see its completion.
    task automatic applyStimulus(input int id, input logic clr, input logic st,
                                 input int xv, input int yv, input int nv, input int ia);
        int seen;
        int t;
        @(negedge clk);
        driveReq(id, clr, st, xv, yv, nv, ia);
        baseCycle = cycleCnt;
        seen = doneCount;
        @(negedge clk);
        releaseReq();
        checkOutput("busyCycle1", 128'(busyOf(id)), 128'(1));
        t = 0;
        while (doneCount == seen && t < 300) begin
            @(negedge clk);
            t++;
        end
        checkOutput("doneSeen", 128'(doneCount - seen), 128'(1));
    endtask

    initial begin
        clk = 1'b0;
        fbInit = 1'b1;
        rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
        releaseReq();
        xA = '0; yA = '0; nA = '0; iA = '0;
        xB = '0; yB = '0; nB = '0; iB = '0;
        xC = '0; yC = '0; nC = '0; iC = '0;
        for (int i = 0; i < 4096; i++) progMem[i] = 8'h00;
        progMem[12'h200] = 8'hF0;
        progMem[12'h201] = 8'h90;
        progMem[12'h202] = 8'h90;
        progMem[12'h203] = 8'h90;
        progMem[12'h204] = 8'hF0;
        progMem[12'h300] = 8'hFF;
        progMem[12'h301] = 8'hFF;
        progMem[12'h302] = 8'hFF;
        for (int i = 0; i < 8; i++) progMem[12'h310 + i] = 8'h81;

        repeat (3) @(negedge clk);
        rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
        fbInit = 1'b0;
        @(negedge clk);

        // Reset state
        checkOutput("rstBusy", 128'(busyA), 128'(0));
        checkOutput("rstDone", 128'(doneA), 128'(0));
        checkOutput("rstCollision", 128'(collA), 128'(0));
        checkOutput("rstWrEn", 128'(fbWrEnC), 128'(0));
        checkOutput("rstMemAddr", 128'(memAddrB), 128'(0));

        // "0" glyph at origin on a blank screen
        pushWr(0, 0, 128'h0000_0000_0000_0000_F000_0000_0000_0000);
        pushWr(0, 1, 128'h0000_0000_0000_0000_9000_0000_0000_0000);
        pushWr(0, 2, 128'h0000_0000_0000_0000_9000_0000_0000_0000);
        pushWr(0, 3, 128'h0000_0000_0000_0000_9000_0000_0000_0000);
        pushWr(0, 4, 128'h0000_0000_0000_0000_F000_0000_0000_0000);
        pushDone(0, 11, 1'b0);
        applyStimulus(0, 1'b0, 1'b1, 0, 0, 5, 12'h200);

        // Same draw again erases it and collides
        for (int r = 0; r < 5; r++) pushWr(0, r, 128'h0);
        pushDone(0, 11, 1'b1);
        applyStimulus(0, 1'b0, 1'b1, 0, 0, 5, 12'h200);

        // n=0: immediate done, collision cleared, no writes
        pushDone(0, 1, 1'b0);
        applyStimulus(0, 1'b0, 1'b1, 3, 3, 0, 12'h200);

        // Wrap in both directions
        pushWr(0, 30, 128'h0000_0000_0000_0000_F000_0000_0000_000F);
        pushWr(0, 31, 128'h0000_0000_0000_0000_F000_0000_0000_000F);
        pushWr(0, 0,  128'h0000_0000_0000_0000_F000_0000_0000_000F);
        pushDone(0, 7, 1'b0);
        applyStimulus(0, 1'b0, 1'b1, 60, 30, 3, 12'h300);

        // Clip: right columns and bottom rows dropped
        pushWr(1, 30, 128'h0000_0000_0000_0000_0000_0000_0000_000F);
        pushWr(1, 31, 128'h0000_0000_0000_0000_0000_0000_0000_000F);
        pushDone(1, 5, 1'b0);
        applyStimulus(1, 1'b0, 1'b1, 60, 30, 3, 12'h300);

        // Large display: wrap, redraw to collide, then clear (start ignored)
        pushWr(2, 62, 128'hF000_0000_0000_0000_0000_0000_0000_000F);
        pushWr(2, 63, 128'hF000_0000_0000_0000_0000_0000_0000_000F);
        pushWr(2, 0,  128'hF000_0000_0000_0000_0000_0000_0000_000F);
        pushDone(2, 7, 1'b0);
        applyStimulus(2, 1'b0, 1'b1, 124, 62, 3, 12'h300);
        pushWr(2, 62, 128'h0);
        pushWr(2, 63, 128'h0);
        pushWr(2, 0,  128'h0);
        pushDone(2, 7, 1'b1);
        applyStimulus(2, 1'b0, 1'b1, 124, 62, 3, 12'h300);
        for (int r = 0; r < 64; r++) pushWr(2, r, 128'h0);
        pushDone(2, 65, 1'b0);
        applyStimulus(2, 1'b1, 1'b1, 5, 5, 4, 12'h200);

        // Reset during the WRITE of row 2 of an 8-row draw. Rows 0..2 are
        // presented before the reset edge; nothing may follow it.
        pushWr(0, 10, 128'h0000_0000_0000_0000_0081_0000_0000_0000);
        pushWr(0, 11, 128'h0000_0000_0000_0000_0081_0000_0000_0000);
        pushWr(0, 12, 128'h0000_0000_0000_0000_0081_0000_0000_0000);
        @(negedge clk);
        driveReq(0, 1'b0, 1'b1, 8, 10, 8, 12'h310);
        baseCycle = cycleCnt;
        @(negedge clk);
        releaseReq();
        while (cycleCnt - baseCycle < 6) @(negedge clk);
        rstA = 1'b1;
        @(negedge clk);
        rstA = 1'b0;
        checkOutput("midRstBusy", 128'(busyA), 128'(0));
        checkOutput("midRstDone", 128'(doneA), 128'(0));
        checkOutput("midRstWrEn", 128'(fbWrEnA), 128'(0));
        checkOutput("midRstMemAddr", 128'(memAddrA), 128'(0));
        checkOutput("midRstRdAddr", 128'(fbRdAddrA), 128'(0));
        checkOutput("midRstWrAddr", 128'(fbWrAddrA), 128'(0));
        checkOutput("midRstWrData", 128'(fbWrDataA), 128'(0));
        repeat (6) @(negedge clk);
        checkOutput("midRstPendingWrites", 128'(expWrQ.size()), 128'(0));

        // Engine accepts a fresh request after the reset
        pushWr(0, 20, 128'h0000_0000_0000_0000_F000_0000_0000_0000);
        pushDone(0, 3, 1'b0);
        applyStimulus(0, 1'b0, 1'b1, 0, 20, 1, 12'h200);

        repeat (4) @(negedge clk);
        checkOutput("queuesEmpty", 128'(expWrQ.size() + expDoneQ.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
